rlo_nest_unit: RTL and testbench

Parametrised successor to the single-bit argument selector in the PLC bit-logic path. Selects one operand bit from immediate, RAM word or register word, applies optional negation, and combines it into a registered RLO (result of logic operation). Provides a bracket-nesting stack for STL-style "A(" / "O(" / ")" sequences. Sits between the instruction decoder and the RLO consumer (assign/jump logic) of each PLC core.

---
 rtl/rlo_nest_unit.sv | 161 ++++++++++++++++
 tb/tb_rlo_nest_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rlo_nest_unit.sv
// rlo_nest_unit: operand selection, negation and RLO combination for the PLC
// bit-logic path, with a bracket-nesting stack for "A(" / "O(" / ")" sequences.
module rlo_nest_unit #(
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 4,
  localparam int SEL_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1,
  localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              EXEC,
  input  logic [1:0]        ARG_OPCode,
  input  logic [SEL_W-1:0]  ARG_BitSel,
  input  logic              ARG_ArgToSet,
  input  logic [DATA_W-1:0] ARG_RAMData,
  input  logic [DATA_W-1:0] ARG_Register,
  input  logic              ARG_Negate,
  input  logic [2:0]        LOGIC_OPCode,
  input  logic              CLR_Err,
  output logic              RLO,
  output logic              ARG,
  output logic [LVL_W-1:0]  NEST_Level,
  output logic              STK_Ovf,
  output logic              STK_Udf
);

  typedef enum logic [2:0] {
    OP_LD       = 3'b000,
    OP_AND      = 3'b001,
    OP_OR       = 3'b010,
    OP_XOR      = 3'b011,
    OP_PUSH_AND = 3'b100,
    OP_PUSH_OR  = 3'b101,
    OP_POP      = 3'b110,
    OP_NOP      = 3'b111
  } logic_op_e;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(STACK_DEPTH);

  logic              rlo_reg, rlo_next;
  logic              arg_reg, arg_next;
  logic              ovf_reg, ovf_next;
  logic              udf_reg, udf_next;
  logic [LVL_W-1:0]  level_reg, level_next;
  logic [1:0]        stack_reg [STACK_DEPTH];
  logic [DATA_W-1:0] ram_shift, reg_shift;
  logic              operand;
  logic              push_en;
  logic [1:0]        top_entry;
  logic [STACK_DEPTH-1:0] wr_hit;
  logic [STACK_DEPTH-1:0] top_hit;
  logic_op_e         op;

  assign op = logic_op_e'(LOGIC_OPCode);

  // Shifting the word right by the bit index leaves the selected bit at [0];
  // indices past the word width shift everything out and read as 0.
  assign ram_shift = ARG_RAMData >> ARG_BitSel;
  assign reg_shift = ARG_Register >> ARG_BitSel;

  // Operand source mux followed by optional inversion.
  always_comb begin
    operand = 1'b0;
    unique case (ARG_OPCode)
      2'b00:   operand = ARG_ArgToSet;
      2'b01:   operand = ram_shift[0];
      2'b10:   operand = reg_shift[0];
      default: operand = rlo_reg;
    endcase
    operand = operand ^ ARG_Negate;
  end

  // Per-entry decode: the write slot is the current level, the top of stack
  // is the entry just below it.
  for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
    assign wr_hit[gi]  = push_en && (level_reg == LVL_W'(gi));
    assign top_hit[gi] = (level_reg == LVL_W'(gi + 1));
  end

  // Read the top-of-stack entry for POP.
  always_comb begin
    top_entry = 2'b00;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (top_hit[i]) top_entry = stack_reg[i];
    end
  end

  // Instruction decode: next RLO/ARG/level, push enable and error flags.
  always_comb begin
    rlo_next   = rlo_reg;
    arg_next   = arg_reg;
    level_next = level_reg;
    push_en    = 1'b0;
    ovf_next   = ovf_reg & ~CLR_Err;
    udf_next   = udf_reg & ~CLR_Err;
    if (EXEC) begin
      unique case (op)
        OP_LD:  begin rlo_next = operand;           arg_next = operand; end
        OP_AND: begin rlo_next = rlo_reg & operand; arg_next = operand; end
        OP_OR:  begin rlo_next = rlo_reg | operand; arg_next = operand; end
        OP_XOR: begin rlo_next = rlo_reg ^ operand; arg_next = operand; end
        OP_PUSH_AND, OP_PUSH_OR: begin
          // A push into a full stack is dropped entirely and only flagged.
          if (level_reg == FULL_LVL) begin
            ovf_next = 1'b1;
          end else begin
            push_en    = 1'b1;
            rlo_next   = operand;
            arg_next   = operand;
            level_next = level_reg + LVL_W'(1);
          end
        end
        OP_POP: begin
          if (level_reg == '0) begin
            udf_next = 1'b1;
          end else begin
            rlo_next   = top_entry[0] ? (top_entry[1] | rlo_reg)
                                      : (top_entry[1] & rlo_reg);
            level_next = level_reg - LVL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Result, operand, level and sticky error registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rlo_reg   <= 1'b0;
      arg_reg   <= 1'b0;
      level_reg <= '0;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else begin
      rlo_reg   <= rlo_next;
      arg_reg   <= arg_next;
      level_reg <= level_next;
      ovf_reg   <= ovf_next;
      udf_reg   <= udf_next;
    end
  end

  // Stack storage: each entry holds {saved RLO, combine op (1 = OR)}.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_reg[i] <= 2'b00;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (wr_hit[i]) stack_reg[i] <= {rlo_reg, LOGIC_OPCode[0]};
      end
    end
  end

  assign RLO        = rlo_reg;
  assign ARG        = arg_reg;
  assign NEST_Level = level_reg;
  assign STK_Ovf    = ovf_reg;
  assign STK_Udf    = udf_reg;

endmodule

// File: tb/tb_rlo_nest_unit.sv
// Testbench for rlo_nest_unit: directed instruction sequences checked every
// cycle against a queue-based behavioural model, plus literal expectations.
module tb_rlo_nest_unit;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       EXEC = 1'b0;
  logic [1:0] ARG_OPCode = 2'b00;
  logic [2:0] ARG_BitSel = 3'd0;
  logic       ARG_ArgToSet = 1'b0;
  logic [7:0] ARG_RAMData = 8'h00;
  logic [7:0] ARG_Register = 8'h00;
  logic       ARG_Negate = 1'b0;
  logic [2:0] LOGIC_OPCode = 3'b111;
  logic       CLR_Err = 1'b0;
  logic       RLO, ARG, STK_Ovf, STK_Udf;
  logic [2:0] NEST_Level;

  int checks = 0;
  int failures = 0;

  rlo_nest_unit #(.DATA_W(DATA_W), .STACK_DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .EXEC(EXEC), .ARG_OPCode(ARG_OPCode),
    .ARG_BitSel(ARG_BitSel), .ARG_ArgToSet(ARG_ArgToSet),
    .ARG_RAMData(ARG_RAMData), .ARG_Register(ARG_Register),
    .ARG_Negate(ARG_Negate), .LOGIC_OPCode(LOGIC_OPCode), .CLR_Err(CLR_Err),
    .RLO(RLO), .ARG(ARG), .NEST_Level(NEST_Level),
    .STK_Ovf(STK_Ovf), .STK_Udf(STK_Udf)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  bit       m_rlo = 0, m_arg = 0, m_ovf = 0, m_udf = 0;
  bit [1:0] m_stk[$];

  function automatic bit model_operand();
    int v;
    case (ARG_OPCode)
      2'b00:   v = ARG_ArgToSet;
      2'b01:   v = (int'(ARG_BitSel) < DATA_W) ? ((int'(ARG_RAMData) >> ARG_BitSel) & 1) : 0;
      2'b10:   v = (int'(ARG_BitSel) < DATA_W) ? ((int'(ARG_Register) >> ARG_BitSel) & 1) : 0;
      default: v = m_rlo;
    endcase
    return bit'(v) ^ ARG_Negate;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    bit a, new_ovf, new_udf;
    bit [1:0] e;
    if (!nRST) begin
      m_rlo = 0; m_arg = 0; m_ovf = 0; m_udf = 0;
      m_stk.delete();
    end else begin
      new_ovf = 0; new_udf = 0;
      a = model_operand();
      if (EXEC) begin
        case (LOGIC_OPCode)
          3'd0: begin m_rlo = a; m_arg = a; end
          3'd1: begin m_rlo = m_rlo & a; m_arg = a; end
          3'd2: begin m_rlo = m_rlo | a; m_arg = a; end
          3'd3: begin m_rlo = m_rlo ^ a; m_arg = a; end
          3'd4, 3'd5: begin
            if (m_stk.size() == DEPTH) new_ovf = 1;
            else begin
              m_stk.push_back({m_rlo, LOGIC_OPCode == 3'd5});
              m_rlo = a; m_arg = a;
            end
          end
          3'd6: begin
            if (m_stk.size() == 0) new_udf = 1;
            else begin
              e = m_stk.pop_back();
              m_rlo = e[0] ? (e[1] | m_rlo) : (e[1] & m_rlo);
            end
          end
          default: ;
        endcase
      end
      m_ovf = new_ovf | (m_ovf & ~CLR_Err);
      m_udf = new_udf | (m_udf & ~CLR_Err);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge CLK) begin
    check("model_rlo", RLO, m_rlo);
    check("model_arg", ARG, m_arg);
    check("model_level", NEST_Level, m_stk.size());
    check("model_ovf", STK_Ovf, m_ovf);
    check("model_udf", STK_Udf, m_udf);
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic [2:0] lop, input logic [1:0] src, input logic imm,
                    input logic [2:0] sel, input logic neg, input logic clr);
    EXEC = 1'b1; LOGIC_OPCode = lop; ARG_OPCode = src; ARG_ArgToSet = imm;
    ARG_BitSel = sel; ARG_Negate = neg; CLR_Err = clr;
    @(posedge CLK); #1;
    $display("op=%0d src=%0d imm=%0d sel=%0d neg=%0d clr=%0d -> RLO=%0d ARG=%0d lvl=%0d ovf=%0d udf=%0d",
             lop, src, imm, sel, neg, clr, RLO, ARG, NEST_Level, STK_Ovf, STK_Udf);
    EXEC = 1'b0; CLR_Err = 1'b0;
  endtask

  task automatic idle(input int n, input logic clr);
    EXEC = 1'b0; CLR_Err = clr;
    repeat (n) begin @(posedge CLK); #1; end
    CLR_Err = 1'b0;
  endtask

  typedef struct { logic [2:0] lop; logic [1:0] src; logic imm; logic [2:0] sel; logic neg; bit exp_rlo; } vec_t;
  vec_t vecs[8];
  bit [2:0] a5_sel[4];
  bit a5_exp[4];

  initial begin
    // Reset then idle
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    #2 nRST = 1'b1;
    idle(5, 1'b0);
    check("idle_rlo", RLO, 0);
    check("idle_arg", ARG, 0);
    check("idle_level", NEST_Level, 0);
    check("idle_flags", {STK_Ovf, STK_Udf}, 0);

    // Bit select from RAM word 8'hA5, back-to-back
    ARG_RAMData = 8'hA5;
    a5_sel = '{3'd0, 3'd1, 3'd2, 3'd7};
    a5_exp = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      op(3'd0, 2'b01, 1'b0, a5_sel[i], 1'b0, 1'b0);
      check("ram_bitsel", RLO, a5_exp[i]);
    end
    op(3'd0, 2'b01, 1'b0, 3'd2, 1'b1, 1'b0);
    check("ram_bitsel_neg", RLO, 0);

    // Nesting: LD 1, PUSH_AND 0, OR 1, POP -> 1,0,1,1 ; then LD 0 variant ends 0
    op(3'd0, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0); check("nest1_ld", RLO, 1);
    op(3'd4, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0); check("nest1_push", RLO, 0); check("nest1_lvl1", NEST_Level, 1);
    op(3'd2, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0); check("nest1_or", RLO, 1);
    op(3'd6, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0); check("nest1_pop", RLO, 1); check("nest1_lvl0", NEST_Level, 0);
    op(3'd0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    op(3'd4, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    op(3'd2, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0);
    op(3'd6, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0); check("nest2_pop", RLO, 0);

    // Misc directed vectors: register source, AND/XOR, RLO source, NOP
    ARG_Register = 8'h3C;
    vecs[0] = '{3'd0, 2'b10, 1'b0, 3'd2, 1'b0, 1'b1};
    vecs[1] = '{3'd1, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[2] = '{3'd2, 2'b00, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[3] = '{3'd3, 2'b10, 1'b0, 3'd5, 1'b0, 1'b0};
    vecs[4] = '{3'd0, 2'b11, 1'b0, 3'd0, 1'b1, 1'b1};
    vecs[5] = '{3'd1, 2'b11, 1'b0, 3'd0, 1'b0, 1'b1};
    vecs[6] = '{3'd3, 2'b00, 1'b1, 3'd0, 1'b1, 1'b1};
    vecs[7] = '{3'd7, 2'b00, 1'b1, 3'd0, 1'b0, 1'b1};
    foreach (vecs[i]) begin
      op(vecs[i].lop, vecs[i].src, vecs[i].imm, vecs[i].sel, vecs[i].neg, 1'b0);
      check("vec_rlo", RLO, vecs[i].exp_rlo);
    end
    check("nop_keeps_arg", ARG, 0);

    // Overflow: 5 PUSH_OR imm1, then a 6th with imm0 must change nothing
    for (int i = 0; i < 5; i++) op(3'd5, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0);
    check("ovf_level", NEST_Level, 4);
    check("ovf_flag", STK_Ovf, 1);
    check("ovf_rlo", RLO, 1);
    op(3'd5, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    check("ovf_rlo_held", RLO, 1);
    check("ovf_arg_held", ARG, 1);
    idle(1, 1'b1);
    check("ovf_cleared", STK_Ovf, 0);
    check("ovf_level_kept", NEST_Level, 4);
    for (int i = 0; i < 4; i++) op(3'd6, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    check("drain_level", NEST_Level, 0);
    check("drain_rlo", RLO, 1);

    // Underflow plus simultaneous clear
    op(3'd6, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    check("udf_flag", STK_Udf, 1);
    check("udf_rlo_held", RLO, 1);
    op(3'd6, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1);
    check("udf_new_wins", STK_Udf, 1);
    // New overflow with clear: overflow set, stale underflow cleared
    for (int i = 0; i < 4; i++) op(3'd4, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    op(3'd4, 2'b00, 1'b1, 3'd0, 1'b0, 1'b1);
    check("clr_other_ovf", STK_Ovf, 1);
    check("clr_other_udf", STK_Udf, 0);
    idle(1, 1'b1);
    for (int i = 0; i < 4; i++) op(3'd6, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);

    // Async reset mid-operation at level 3
    op(3'd0, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) op(3'd4, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0);
    check("pre_rst_level", NEST_Level, 3);
    #2 nRST = 1'b0;
    #1;
    check("async_rlo", RLO, 0);
    check("async_arg", ARG, 0);
    check("async_level", NEST_Level, 0);
    check("async_flags", {STK_Ovf, STK_Udf}, 0);
    @(negedge CLK); #2 nRST = 1'b1;
    op(3'd6, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    check("post_rst_udf", STK_Udf, 1);
    check("post_rst_level", NEST_Level, 0);
    idle(2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
